// File: rtl/ppc_pkg.sv
// Shared widths and the fetch-queue entry type for the instruction-fetch path.
// Bit numbering is little-endian here: big-endian bit k maps to bit 63-k.
package ppc_pkg;
    localparam int PC_W     = 64;
    localparam int DWADDR_W = 61;
    localparam int INSTR_W  = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Big-endian word order: the word at pc[2]=0 sits in the upper half.
    function automatic logic [INSTR_W-1:0] sel_word(input logic [63:0] data, input logic odd);
        return odd ? data[31:0] : data[63:32];
    endfunction
endpackage

// File: rtl/ifq_ring.sv
// DEPTH-entry ring buffer for fetched instructions: storage, pointers and occupancy.
// Flush empties the ring without moving the read pointer so the head output stays stable.
module ifq_ring
    import ppc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push_i,
    input  fetch_entry_t                    push_data_i,
    input  logic                            pop_i,
    input  logic                            flush_i,
    output fetch_entry_t                    head_o,
    output logic [PC_W-1:0]                 next_pc_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic [DEPTH-1:0][DWADDR_W-1:0]  dw_o,
    output logic [DEPTH-1:0]                vld_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off      = PTR_W'(i) - rd_ptr_q;
            vld_o[i] = {1'b0, off} < count_q;
            dw_o[i]  = mem_q[i].pc[PC_W-1:3];
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign next_pc_o = mem_q[rd_ptr_q + PTR_W'(1)].pc;
    assign count_o   = count_q;
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues doubleword reads, buffers instructions for decode.
// Define IFQ_SMC_SNOOP_EN to flush on stores that hit queued or in-flight fetches.
module ifetch_queue
    import ppc_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    mem_rd_en,
    output logic [DWADDR_W-1:0]     mem_rd_addr,
    input  logic [63:0]             mem_rd_data,
    input  logic                    redirect,
    input  logic [PC_W-1:0]         redirect_pc,
    input  logic                    snoop_wr_en,
    input  logic [DWADDR_W-1:0]     snoop_wr_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [$clog2(DEPTH):0]  out_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]                fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic                           inflight_q, inflight_d;
    logic                           pop, push, flush, snoop_flush;
    logic [PC_W-1:0]                restart_pc;
    fetch_entry_t                   head, push_data;
    logic [PC_W-1:0]                ring_next_pc;
    logic [DEPTH-1:0][DWADDR_W-1:0] ring_dw;
    logic [DEPTH-1:0]               ring_vld;
    logic [CNT_W-1:0]               count;

    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign flush     = redirect | snoop_flush;
    // Reservation counts the in-flight response so the ring can never overflow.
    assign mem_rd_en = rst_n & ~flush & ((count + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
    assign mem_rd_addr = fetch_pc_q[PC_W-1:3];

    assign push            = inflight_q & ~flush;
    assign push_data.pc    = req_pc_q;
    assign push_data.instr = sel_word(mem_rd_data, req_pc_q[2]);

`ifdef IFQ_SMC_SNOOP_EN
    logic hit;
    always_comb begin
        hit = inflight_q && (req_pc_q[PC_W-1:3] == snoop_wr_addr);
        for (int i = 0; i < DEPTH; i++)
            if (ring_vld[i] && ring_dw[i] == snoop_wr_addr) hit = 1'b1;
    end
    assign snoop_flush = snoop_wr_en & hit;

    // Oldest instruction decode has not taken: queue entry, then in-flight, then fetch_pc.
    always_comb begin
        if (count > CNT_W'(pop)) restart_pc = pop ? ring_next_pc : head.pc;
        else if (inflight_q)     restart_pc = req_pc_q;
        else                     restart_pc = fetch_pc_q;
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{snoop_wr_en, snoop_wr_addr, ring_dw, ring_vld, ring_next_pc};
    assign snoop_flush  = 1'b0;
    assign restart_pc   = fetch_pc_q;
`endif

    logic unused_lo;
    assign unused_lo = ^redirect_pc[1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = mem_rd_en;
        if (redirect)         fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        else if (snoop_flush) fetch_pc_d = restart_pc;
        else if (mem_rd_en) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    ifq_ring #(.DEPTH(DEPTH)) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .next_pc_o   (ring_next_pc),
        .count_o     (count),
        .dw_o        (ring_dw),
        .vld_o       (ring_vld)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_count = count;
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mem_rd_en, output, 1, instruction-memory read request.
REQ-006 SHALL have port mem_rd_addr, output, 61, doubleword address, equal to fetch_pc[0:60].
REQ-007 SHALL have port mem_rd_data, input, 64, read data, valid the cycle after mem_rd_en.
REQ-008 SHALL have port redirect, input, 1, branch taken; flush queue and refetch.
REQ-009 SHALL have port redirect_pc, input, 64, redirect target; bits [62:63] ignored, treated as 00.
REQ-010 SHALL have port snoop_wr_en, input, 1, data-memory store in progress.
REQ-011 SHALL have port snoop_wr_addr, input, 61, doubleword address of that store.
REQ-012 SHALL have port out_valid, output, 1, head entry available to decode.
REQ-013 SHALL have port out_ready, input, 1, decode accepts head entry.
REQ-014 SHALL have port out_pc, output, 64, PC of head entry.
REQ-015 SHALL have port out_instr, output, 32, instruction of head entry.
REQ-016 SHALL have port out_count, output, log2(DEPTH)+1, number of valid queue entries.

Function
REQ-017 SHALL issue at most one read per cycle: mem_rd_en=1 when count + inflight < DEPTH and no redirect or snoop flush this cycle.
REQ-018 SHALL advance fetch_pc by 4 per issued read, wrapping modulo 2^64.
REQ-019 SHALL select mem_rd_data[32:63] when bit 61 of the request PC is 1, else mem_rd_data[0:31].
REQ-020 SHALL write each response into the queue tail at the end of the response cycle; out_valid rises the following cycle, giving 2-cycle fetch-to-valid latency with no bypass.
REQ-021 SHALL pop the head when out_valid and out_ready are both 1; a pop and a push in the same cycle SHALL leave count unchanged.
REQ-022 SHALL hold out_valid=0 and out_pc/out_instr stable when the queue is empty.
REQ-023 SHALL never overflow: count + inflight <= DEPTH at all times; read and write pointers wrap modulo DEPTH.
REQ-024 On redirect, SHALL clear the queue, discard the in-flight response, set fetch_pc=redirect_pc, and issue a read for redirect_pc the next cycle.
REQ-025 Redirect SHALL take priority over a same-cycle pop, push and snoop; the popped entry is dropped.
REQ-026 On snoop match (snoop_wr_addr equals [0:60] of any queued or in-flight PC), SHALL flush as for redirect, restarting at the PC of the oldest instruction not accepted this cycle.
REQ-027 A snoop that matches no queued or in-flight PC SHALL have no effect.

Reset
REQ-028 While rst_n=0: fetch_pc=RESET_PC, count=0, inflight=0, mem_rd_en=0, out_valid=0, out_pc=0, out_instr=0, out_count=0.
REQ-029 SHALL issue the first read for RESET_PC in the first clock edge cycle after rst_n deasserts; reset asserted mid-operation SHALL discard all entries and the in-flight response.

Configuration
REQ-030 Macro IFQ_SMC_SNOOP_EN defined: REQ-026 snoop flushing is active.
REQ-031 Macro IFQ_SMC_SNOOP_EN undefined: snoop_wr_en and snoop_wr_addr remain as ports, are ignored, and no compare logic is built.

Structure
REQ-032 Package ppc_pkg SHALL hold PC_W=64, DWADDR_W=61, INSTR_W=32, and the fetch_entry_t struct {pc, instr}.
REQ-033 SHALL instantiate one sub-module, ifq_ring, implementing the DEPTH-entry ring storage, pointers and count; fetch control stays in ifetch_queue.

Verification
REQ-034 Reset release, out_ready=1, memory returns the sequential word values -> out_pc sequence 0,4,8,..., first out_valid 2 cycles after the first mem_rd_en.
REQ-035 DEPTH=4, out_ready=0 for 10 cycles -> exactly 4 reads issued, out_count=4, mem_rd_en=0 until the first pop.
REQ-036 Redirect to 0x104 while 3 entries are queued and one is in flight -> out_valid=0 next cycle, stale response dropped, next out_pc=0x104, out_instr=mem[0x104][32:63].
REQ-037 Snoop of address 0x1 (PC 0x8/0xC) while PCs 0x8..0x14 are queued and head 0x8 is not accepted -> flush, refetch begins at 0x8; with the macro undefined -> no flush.
REQ-038 Redirect, snoop match, and pop in the same cycle -> redirect wins, restart at redirect_pc.
REQ-039 rst_n asserted with 2 entries queued -> all outputs at reset values immediately (asynchronous); after release, fetch restarts at RESET_PC.
